// File: rtl/decode_ctrl_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | decode_ctrl_pipe : RV32I/RV64I decode stage registered into the ID/EX slot, |
// |                    with load-use bubble insertion and redirect flush.       |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
module decode_ctrl_pipe #(
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [2:0]      out_imm_sel,
  output logic            out_reg_wen,
  output logic            out_a_sel,
  output logic            out_b_sel,
  output logic            out_mem_rw,
  output logic [1:0]      out_wb_sel,
  output logic            out_br_un,
  output logic [2:0]      out_branch,
  output logic            out_jump,
  output logic            out_is_load,
  output logic            out_mdu,
  output logic            out_illegal
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011, IMM_J = 3'b100, IMM_NONE = 3'b111;
  localparam logic [1:0] WB_MEM = 2'b00, WB_ALU = 2'b01, WB_PC4 = 2'b10, WB_NONE = 2'b11;
  localparam logic [2:0] BR_NONE = 3'b111;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      imm_sel;
    logic            reg_wen;
    logic            a_sel;
    logic            b_sel;
    logic            mem_rw;
    logic [1:0]      wb_sel;
    logic            br_un;
    logic [2:0]      branch;
    logic            jump;
    logic            is_load;
    logic            mdu;
    logic            illegal;
  } ctrl_t;

  localparam ctrl_t BUBBLE = '{pc: '0, imm: '0, rs1: 5'd0, rs2: 5'd0, rd: 5'd0,
                               imm_sel: IMM_NONE, reg_wen: 1'b0, a_sel: 1'b0, b_sel: 1'b0,
                               mem_rw: 1'b0, wb_sel: WB_NONE, br_un: 1'b0, branch: BR_NONE,
                               jump: 1'b0, is_load: 1'b0, mdu: 1'b0, illegal: 1'b0};

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        rs1_used;
  logic        rs2_used;
  logic        hazard;
  logic [31:0] imm32;
  ctrl_t       dec;
  ctrl_t       held;
  logic        valid;

  assign opcode = in_inst[6:0];
  assign funct3 = in_inst[14:12];
  assign funct7 = in_inst[31:25];

  always_comb begin
    dec         = BUBBLE;
    rs1_used    = 1'b0;
    rs2_used    = 1'b0;
    dec.pc      = in_pc;
    dec.rs1     = in_inst[19:15];
    dec.rs2     = in_inst[24:20];
    dec.rd      = in_inst[11:7];
    dec.is_load = (opcode == OPC_LOAD);
    case (opcode)
      OPC_LUI: begin
        dec.imm_sel = IMM_U; dec.reg_wen = 1'b1; dec.b_sel = 1'b1; dec.wb_sel = WB_ALU;
      end
      OPC_AUIPC: begin
        dec.imm_sel = IMM_U; dec.reg_wen = 1'b1; dec.a_sel = 1'b1; dec.b_sel = 1'b1;
        dec.wb_sel  = WB_ALU;
      end
      OPC_JAL: begin
        dec.imm_sel = IMM_J; dec.reg_wen = 1'b1; dec.a_sel = 1'b1; dec.b_sel = 1'b1;
        dec.wb_sel  = WB_PC4; dec.jump = 1'b1;
      end
      OPC_JALR: begin
        rs1_used    = 1'b1;
        dec.imm_sel = IMM_I; dec.reg_wen = 1'b1; dec.b_sel = 1'b1; dec.wb_sel = WB_PC4;
        dec.jump    = 1'b1;
        dec.illegal = (funct3 != 3'b000);
      end
      OPC_BRANCH: begin
        rs1_used    = 1'b1; rs2_used = 1'b1;
        dec.imm_sel = IMM_B; dec.a_sel = 1'b1; dec.b_sel = 1'b1;
        dec.br_un   = funct3[2] & funct3[1];
        // funct3 {000,001,100,101,110,111} packs densely onto codes 0..5
        dec.branch  = funct3[2] ? {funct3[1], ~funct3[1], funct3[0]} : {2'b00, funct3[0]};
        dec.illegal = (funct3[2:1] == 2'b01);
      end
      OPC_LOAD: begin
        rs1_used    = 1'b1;
        dec.imm_sel = IMM_I; dec.reg_wen = 1'b1; dec.b_sel = 1'b1; dec.wb_sel = WB_MEM;
        dec.illegal = !((funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) ||
                        (XLEN == 64 && (funct3 == 3'b011 || funct3 == 3'b110)));
      end
      OPC_STORE: begin
        rs1_used    = 1'b1; rs2_used = 1'b1;
        dec.imm_sel = IMM_S; dec.b_sel = 1'b1; dec.mem_rw = 1'b1;
        dec.illegal = funct3[2] || (funct3 == 3'b011 && XLEN != 64);
      end
      OPC_OPIMM: begin
        rs1_used    = 1'b1;
        dec.imm_sel = IMM_I; dec.reg_wen = 1'b1; dec.b_sel = 1'b1; dec.wb_sel = WB_ALU;
      end
      OPC_OP: begin
        rs1_used    = 1'b1; rs2_used = 1'b1;
        dec.reg_wen = 1'b1; dec.wb_sel = WB_ALU;
        if (ENABLE_M && funct7 == 7'b0000001) dec.mdu = 1'b1;
        else dec.illegal = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
      end
      default: dec.illegal = 1'b1;
    endcase
    if (dec.illegal) begin
      dec.imm_sel = IMM_NONE; dec.reg_wen = 1'b0; dec.a_sel = 1'b0; dec.b_sel = 1'b0;
      dec.mem_rw  = 1'b0; dec.wb_sel = WB_NONE; dec.br_un = 1'b0; dec.branch = BR_NONE;
      dec.jump    = 1'b0; dec.mdu = 1'b0;
    end
    dec.imm = {{(XLEN-31){imm32[31]}}, imm32[30:0]};
  end

  always_comb begin
    case (dec.imm_sel)
      IMM_I:   imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
      IMM_S:   imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      IMM_B:   imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                        in_inst[11:8], 1'b0};
      IMM_U:   imm32 = {in_inst[31:12], 12'b0};
      IMM_J:   imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                        in_inst[30:21], 1'b0};
      default: imm32 = 32'd0;
    endcase
  end

  assign hazard = valid && held.is_load && (held.rd != 5'd0) && in_valid &&
                  ((rs1_used && dec.rs1 == held.rd) || (rs2_used && dec.rs2 == held.rd));
  assign in_ready = !flush && (!valid || out_ready) && !hazard;

  // Stalled-but-draining cycles fall through to the bubble branch.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      valid <= 1'b0;
      held  <= BUBBLE;
    end else if (in_valid && in_ready) begin
      valid <= 1'b1;
      held  <= dec;
    end else if (!valid || out_ready) begin
      valid <= 1'b0;
      held  <= BUBBLE;
    end
  end

  assign out_valid   = valid;
  assign out_pc      = held.pc;
  assign out_imm     = held.imm;
  assign out_rs1     = held.rs1;
  assign out_rs2     = held.rs2;
  assign out_rd      = held.rd;
  assign out_imm_sel = held.imm_sel;
  assign out_reg_wen = held.reg_wen;
  assign out_a_sel   = held.a_sel;
  assign out_b_sel   = held.b_sel;
  assign out_mem_rw  = held.mem_rw;
  assign out_wb_sel  = held.wb_sel;
  assign out_br_un   = held.br_un;
  assign out_branch  = held.branch;
  assign out_jump    = held.jump;
  assign out_is_load = held.is_load;
  assign out_mdu     = held.mdu;
  assign out_illegal = held.illegal;

endmodule
`default_nettype wire

// File: tb/tb_decode_ctrl_pipe.sv
`default_nettype none
// Bench for decode_ctrl_pipe: RV32 base instance and RV64+M instance share one stimulus
// stream; decoded records go through a scoreboard queue, corner cases are sequenced by hand.
module tb_decode_ctrl_pipe;

  logic        clk = 1'b0;
  always #10 clk = ~clk;

  logic        rst_n, in_valid, flush, out_ready;
  logic [31:0] in_inst, in_pc;
  logic [63:0] in_pc64;
  assign in_pc64 = {32'h0, in_pc};

  logic        a_in_ready, a_out_valid, a_reg_wen, a_a_sel, a_b_sel, a_mem_rw, a_br_un;
  logic        a_jump, a_is_load, a_mdu, a_illegal;
  logic [31:0] a_pc, a_imm;
  logic [4:0]  a_rs1, a_rs2, a_rd;
  logic [2:0]  a_imm_sel, a_branch;
  logic [1:0]  a_wb_sel;

  logic        b_in_ready, b_out_valid, b_reg_wen, b_a_sel, b_b_sel, b_mem_rw, b_br_un;
  logic        b_jump, b_is_load, b_mdu, b_illegal;
  logic [63:0] b_pc, b_imm;
  logic [4:0]  b_rs1, b_rs2, b_rd;
  logic [2:0]  b_imm_sel, b_branch;
  logic [1:0]  b_wb_sel;

  decode_ctrl_pipe #(.XLEN(32), .ENABLE_M(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready), .in_inst(in_inst),
    .in_pc(in_pc), .flush(flush), .out_ready(out_ready), .out_valid(a_out_valid),
    .out_pc(a_pc), .out_imm(a_imm), .out_rs1(a_rs1), .out_rs2(a_rs2), .out_rd(a_rd),
    .out_imm_sel(a_imm_sel), .out_reg_wen(a_reg_wen), .out_a_sel(a_a_sel),
    .out_b_sel(a_b_sel), .out_mem_rw(a_mem_rw), .out_wb_sel(a_wb_sel), .out_br_un(a_br_un),
    .out_branch(a_branch), .out_jump(a_jump), .out_is_load(a_is_load), .out_mdu(a_mdu),
    .out_illegal(a_illegal));

  decode_ctrl_pipe #(.XLEN(64), .ENABLE_M(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready), .in_inst(in_inst),
    .in_pc(in_pc64), .flush(flush), .out_ready(out_ready), .out_valid(b_out_valid),
    .out_pc(b_pc), .out_imm(b_imm), .out_rs1(b_rs1), .out_rs2(b_rs2), .out_rd(b_rd),
    .out_imm_sel(b_imm_sel), .out_reg_wen(b_reg_wen), .out_a_sel(b_a_sel),
    .out_b_sel(b_b_sel), .out_mem_rw(b_mem_rw), .out_wb_sel(b_wb_sel), .out_br_un(b_br_un),
    .out_branch(b_branch), .out_jump(b_jump), .out_is_load(b_is_load), .out_mdu(b_mdu),
    .out_illegal(b_illegal));

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [2:0]  imm_sel;
    logic [63:0] imm;
    logic        wen, a, b, mem;
    logic [1:0]  wb;
    logic [2:0]  br;
    logic        un, jmp, ld, ill;
    logic        ill_m, wen_m, mdu_m;
  } vec_t;

  localparam int NV = 19;
  vec_t tbl[NV];
  vec_t sb_q[$];
  vec_t cur;
  int   checks = 0;
  int   passes = 0;
  bit   acc;

  function automatic vec_t mk(input logic [31:0] inst, input logic [2:0] sel,
                              input logic [63:0] imm, input logic wen, a, b, mem,
                              input logic [1:0] wb, input logic [2:0] br,
                              input logic un, jmp, ld);
    vec_t v;
    v.inst = inst; v.pc = 32'h0; v.imm_sel = sel; v.imm = imm; v.wen = wen; v.a = a;
    v.b = b; v.mem = mem; v.wb = wb; v.br = br; v.un = un; v.jmp = jmp; v.ld = ld;
    v.ill = 1'b0; v.ill_m = 1'b0; v.wen_m = wen; v.mdu_m = 1'b0;
    return v;
  endfunction

  function automatic vec_t bad(input logic [31:0] inst, input logic ld);
    vec_t v;
    v = mk(inst, 3'b111, 64'h0, 0, 0, 0, 0, 2'b11, 3'b111, 0, 0, ld);
    v.ill = 1'b1; v.ill_m = 1'b1;
    return v;
  endfunction

  function automatic logic [135:0] exp32(input vec_t e);
    return {40'h0, e.pc, e.imm[31:0], e.inst[19:15], e.inst[24:20], e.inst[11:7], e.imm_sel,
            e.wen, e.a, e.b, e.mem, e.wb, e.br, e.un, e.jmp, e.ld, 1'b0, e.ill};
  endfunction

  function automatic logic [135:0] act32();
    return {40'h0, a_pc, a_imm, a_rs1, a_rs2, a_rd, a_imm_sel, a_reg_wen, a_a_sel, a_b_sel,
            a_mem_rw, a_wb_sel, a_branch, a_br_un, a_jump, a_is_load, a_mdu, a_illegal};
  endfunction

  function automatic logic [135:0] exp64(input vec_t e);
    return {5'h0, e.imm, e.ill_m, e.wen_m, e.mdu_m, 32'h0, e.pc};
  endfunction

  function automatic logic [135:0] act64();
    return {5'h0, b_imm, b_illegal, b_reg_wen, b_mdu, b_pc};
  endfunction

  task automatic chk(input string name, input logic [135:0] act, input logic [135:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passes++;
  endtask

  // Inputs are driven 1 time unit after a rising edge; sampling happens mid-cycle.
  task automatic step();
    vec_t e;
    #5;
    if (rst_n && a_out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        $display("FAIL sb_underflow: got unexpected output pc %h expected none", a_pc);
      end else begin
        e = sb_q.pop_front();
        chk($sformatf("dec32_%08h", e.inst), act32(), exp32(e));
        chk($sformatf("dec64_%08h", e.inst), act64(), exp64(e));
      end
    end
    acc = rst_n && in_valid && a_in_ready;
    if (acc) sb_q.push_back(cur);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v, input logic [31:0] pc);
    v.pc     = pc;
    cur      = v;
    in_inst  = v.inst;
    in_pc    = pc;
    in_valid = 1'b1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 10 && sb_q.size() > 0; n++) step();
    if (sb_q.size() > 0) begin
      checks++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  vec_t v_addi, v_sub, v_lw, v_add, v_lw0, v_add0, v_rst;

  initial begin
    tbl[0]  = mk(32'hFFF00093, 3'b000, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 1, 0, 2'b01, 3'b111, 0, 0, 0);
    tbl[1]  = mk(32'h00208463, 3'b010, 64'd8, 0, 1, 1, 0, 2'b11, 3'b000, 0, 0, 0);
    tbl[2]  = mk(32'h00412283, 3'b000, 64'd4, 1, 0, 1, 0, 2'b00, 3'b111, 0, 0, 1);
    tbl[3]  = mk(32'h00312623, 3'b001, 64'd12, 0, 0, 1, 1, 2'b11, 3'b111, 0, 0, 0);
    tbl[4]  = mk(32'hFE312E23, 3'b001, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 1, 1, 2'b11, 3'b111, 0, 0, 0);
    tbl[5]  = mk(32'h800003B7, 3'b011, 64'hFFFF_FFFF_8000_0000, 1, 0, 1, 0, 2'b01, 3'b111, 0, 0, 0);
    tbl[6]  = mk(32'h00001197, 3'b011, 64'h1000, 1, 1, 1, 0, 2'b01, 3'b111, 0, 0, 0);
    tbl[7]  = mk(32'h001000EF, 3'b100, 64'h800, 1, 1, 1, 0, 2'b10, 3'b111, 0, 1, 0);
    tbl[8]  = mk(32'hFFDFF06F, 3'b100, 64'hFFFF_FFFF_FFFF_FFFC, 1, 1, 1, 0, 2'b10, 3'b111, 0, 1, 0);
    tbl[9]  = mk(32'h008300E7, 3'b000, 64'd8, 1, 0, 1, 0, 2'b10, 3'b111, 0, 1, 0);
    tbl[10] = bad(32'h008310E7, 0);
    tbl[11] = mk(32'h0020F863, 3'b010, 64'd16, 0, 1, 1, 0, 2'b11, 3'b101, 1, 0, 0);
    tbl[12] = mk(32'h0020C463, 3'b010, 64'd8, 0, 1, 1, 0, 2'b11, 3'b010, 0, 0, 0);
    tbl[13] = bad(32'h0020A463, 0);
    tbl[14] = mk(32'h402081B3, 3'b111, 64'h0, 1, 0, 0, 0, 2'b01, 3'b111, 0, 0, 0);
    tbl[15] = bad(32'h02208033, 0);
    tbl[15].ill_m = 1'b0; tbl[15].wen_m = 1'b1; tbl[15].mdu_m = 1'b1;
    tbl[16] = bad(32'h0000007F, 0);
    tbl[17] = bad(32'h00417283, 1);
    tbl[18] = tbl[0];

    v_addi = tbl[0];
    v_sub  = tbl[14];
    v_lw   = tbl[2];
    v_add  = mk(32'h00128333, 3'b111, 64'h0, 1, 0, 0, 0, 2'b01, 3'b111, 0, 0, 0);
    v_lw0  = mk(32'h00412003, 3'b000, 64'd4, 1, 0, 1, 0, 2'b00, 3'b111, 0, 0, 1);
    v_add0 = mk(32'h00100333, 3'b111, 64'h0, 1, 0, 0, 0, 2'b01, 3'b111, 0, 0, 0);
    v_rst  = mk(32'h0, 3'b111, 64'h0, 0, 0, 0, 0, 2'b11, 3'b111, 0, 0, 0);

    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_inst = 32'h0; in_pc = 32'h0; cur = v_rst;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", a_out_valid, 0);
    chk("reset_fields", act32(), exp32(v_rst));
    rst_n = 1'b1;
    #1;
    chk("reset_in_ready", a_in_ready, 1);

    out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      int n;
      drive(tbl[i], 32'h1000 + 32'(4 * i));
      n = 0;
      do begin step(); n++; end while (!acc && n < 8);
      if (!acc) begin
        checks++;
        $display("FAIL accept_timeout_%0d: got no accept expected accept", i);
      end
    end
    drain();

    // Load-use with a real destination: exactly one bubble.
    drive(v_lw, 32'h2000);
    step();
    drive(v_add, 32'h2004);
    #1 chk("lu_stall_ready", a_in_ready, 0);
    step();
    chk("lu_bubble_valid", a_out_valid, 0);
    chk("lu_resume_ready", a_in_ready, 1);
    step();
    chk("lu_add_held", act32(), exp32(cur));
    drain();

    // Load into x0 never stalls.
    drive(v_lw0, 32'h2100);
    step();
    drive(v_add0, 32'h2104);
    #1 chk("lu_x0_ready", a_in_ready, 1);
    step();
    chk("lu_x0_no_bubble", a_out_valid, 1);
    drain();

    // Backpressure for three cycles, then release takes the next word on the same edge.
    drive(v_addi, 32'h3000);
    step();
    out_ready = 1'b0;
    drive(v_sub, 32'h3004);
    for (int k = 0; k < 3; k++) begin
      vec_t h;
      h = v_addi; h.pc = 32'h3000;
      #1 chk($sformatf("bp_ready_%0d", k), a_in_ready, 0);
      step();
      chk($sformatf("bp_hold_%0d", k), act32(), exp32(h));
    end
    out_ready = 1'b1;
    #1 chk("bp_release_ready", a_in_ready, 1);
    step();
    chk("bp_next_held", act32(), exp32(cur));
    drain();

    // Flush while holding and offering a new word.
    drive(v_addi, 32'h4000);
    step();
    out_ready = 1'b0;
    flush     = 1'b1;
    drive(v_sub, 32'h4004);
    #1 chk("flush_ready", a_in_ready, 0);
    step();
    chk("flush_kill", a_out_valid, 0);
    sb_q.delete();
    flush = 1'b0; out_ready = 1'b1;
    step();
    chk("flush_word_kept", act32(), exp32(cur));
    drain();

    // Flush during a load-use hazard wins over the hold.
    drive(v_lw, 32'h5000);
    step();
    out_ready = 1'b0;
    flush     = 1'b1;
    drive(v_add, 32'h5004);
    #1 chk("flush_hz_ready", a_in_ready, 0);
    step();
    chk("flush_hz_kill", a_out_valid, 0);
    sb_q.delete();
    flush = 1'b0; out_ready = 1'b1;
    step();
    chk("flush_hz_add", act32(), exp32(cur));
    drain();

    // Reset while a word is held discards it.
    drive(v_addi, 32'h6000);
    step();
    rst_n = 1'b0; in_valid = 1'b0;
    step();
    chk("reset_mid_valid", a_out_valid, 0);
    chk("reset_mid_fields", act32(), exp32(v_rst));
    sb_q.delete();
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
